// File: rtl/kalman_state_uart_tx.sv
// UART transmitter for one Kalman state estimate. Each frame is a sync header,
// the state words (MSB byte first) and an XOR checksum, sent as 8N1 and LSB first.
module kalman_state_uart_tx #(
  parameter int         WIDTH        = 16,
  parameter int         nos          = 3,
  parameter int         intDigits    = 4,
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             start,
  input  logic [WIDTH-1:0] State [0:nos-1],
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int NDATA  = nos * WIDTH / 8;
  localparam int NBYTES = NDATA + 2;
  localparam int SW     = nos * WIDTH;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BYTE_W = $clog2(NBYTES);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);

  // The fixed-point split never changes the framing; only the word size must be whole bytes.
  if ((WIDTH % 8) != 0 || CLKS_PER_BIT < 2 || intDigits > WIDTH) begin : g_param_check
    $error("kalman_state_uart_tx: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e            state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_q;
  logic [BYTE_W-1:0] byte_q;
  logic [SW-1:0]     shadow_q;
  logic [SW-1:0]     shadow_d;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;
  logic [7:0]        chk;
  logic [7:0]        cur_byte;

  // State[0] sits in the top bits so byte j of the frame payload is a simple downward slice.
  always_comb begin
    shadow_d = '0;
    for (int k = 0; k < nos; k++) begin
      shadow_d[SW-1-k*WIDTH -: WIDTH] = State[k];
    end
  end

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    chk      = '0;
    cur_byte = HEADER;
    for (int j = 0; j < NDATA; j++) begin
      chk = chk ^ shadow_q[SW-1-8*j -: 8];
      if (byte_q == BYTE_W'(j + 1)) cur_byte = shadow_q[SW-1-8*j -: 8];
    end
    if (byte_q == BYTE_LAST) cur_byte = chk;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the shadow register is a plain register bank, not a RAM, so it can be
      // cleared here and an aborted frame leaves no stale payload behind.
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      shadow_q <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // done is a single-cycle pulse and must drop even while clk_en is low.
      done_q <= 1'b0;
      if (clk_en) begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              shadow_q <= shadow_d;
              busy_q   <= 1'b1;
              tx_q     <= 1'b0;
              baud_q   <= '0;
              bit_q    <= '0;
              byte_q   <= '0;
              state_q  <= S_START;
            end
          end
          S_START: begin
            if (baud_q == BAUD_LAST) begin
              baud_q  <= '0;
              bit_q   <= '0;
              tx_q    <= cur_byte[0];
              state_q <= S_DATA;
            end else begin
              baud_q <= baud_q + 1'b1;
            end
          end
          S_DATA: begin
            if (baud_q == BAUD_LAST) begin
              baud_q <= '0;
              if (bit_q == 3'd7) begin
                tx_q    <= 1'b1;
                state_q <= S_STOP;
              end else begin
                bit_q <= bit_q + 3'd1;
                tx_q  <= cur_byte[bit_q + 3'd1];
              end
            end else begin
              baud_q <= baud_q + 1'b1;
            end
          end
          S_STOP: begin
            if (baud_q == BAUD_LAST) begin
              baud_q <= '0;
              if (byte_q == BYTE_LAST) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_IDLE;
              end else begin
                byte_q  <= byte_q + 1'b1;
                tx_q    <= 1'b0;
                state_q <= S_START;
              end
            end else begin
              baud_q <= baud_q + 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
